sdram_chip_model: RTL
=====================

Name: sdram_chip_model

Overview:
- Synthesizable single-chip SDR SDRAM responder: the device end of the 16-bit MT48LC16M16-style bus that the core SDRAM controllers drive.
- Decodes ACTIVE / READ / WRITE / PRECHARGE / AUTO_REFRESH / LOAD_MODE.
- Backs data with a byte-enabled block RAM and returns read data at the programmed CAS latency.
- Used in simulation benches and on-FPGA loopback tests of controllers.
- Tracks per-bank row state and reports protocol/timing violations through sticky error flags.

Parameters:
- ADDR_W, 16: backing-store word-address width; the device address {BA, row, col} is truncated to its low ADDR_W bits.
- COL_W, 9: column bits taken from SDRAM_A at READ/WRITE.
- T_RCD, 2: minimum cycles from ACTIVE to READ/WRITE in the same bank.
- T_RP, 2: minimum cycles from PRECHARGE to ACTIVE/AUTO_REFRESH.

Ports:
- clk  in  1  device clock; all pins sampled on its rising edge.
- reset  in  1  synchronous, active-high.
- SDRAM_A  in  13  multiplexed address.
- SDRAM_BA  in  2  bank.
- SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE  in  1 each  command pins.
- SDRAM_CKE  in  1  clock enable; when 0 the command is ignored.
- SDRAM_DQML, SDRAM_DQMH  in  1 each  write byte masks (1 = masked).
- SDRAM_DQ_I  in  16  data from controller.
- SDRAM_DQ_O  out  16  read data.
- SDRAM_DQ_OE  out  1  read-data drive enable.
- err  out  6  sticky violation flags.
- refresh_cnt  out  16  saturating AUTO_REFRESH count.

Behaviour:
- Reset values: DQ_OE=0, DQ_O=0, err=0, refresh_cnt=0. Also cleared: all banks idle, mode_valid=0, CL=2, read pipeline flushed, timers expired. RAM contents are preserved.
- A command is valid when nCS=0 and CKE=1. Encoding {nRAS,nCAS,nWE}:
  - 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE.
  - 111 NOP and 110 BURST_TERMINATE take no action.
- Per-bank state machine: IDLE -> ACTIVE(row) on ACTIVE; ACTIVE -> IDLE on PRECHARGE, or on READ/WRITE with A[10]=1 (auto-precharge takes effect after the access).
- LOAD_MODE: latch CL=A[6:4] and BL=A[2:0]; set mode_valid.
  - CL not 2 or 3, or BL not 0: set err[0]; CL stays at its previous value.
  - Requires all banks IDLE, else err[1].
- ACTIVE:
  - Bank already ACTIVE: err[1]; the row is overwritten.
  - Fewer than T_RP cycles since a PRECHARGE of that bank: err[2].
  - Otherwise latch row=A, start that bank's tRCD counter.
- READ/WRITE:
  - Bank IDLE: err[1], command dropped.
  - tRCD not elapsed: err[2], command still executed.
  - mode_valid=0: err[0], command executed with CL=2.
  - Word address = {BA, row, A[COL_W-1:0]} truncated to ADDR_W.
- WRITE:
  - Data sampled from DQ_I on the command edge.
  - Low byte written iff DQML=0; high byte written iff DQMH=0.
- READ:
  - Command sampled at edge T.
  - DQ_OE=1 and DQ_O=word for exactly the cycle between edges T+CL-1 and T+CL, so the controller samples it at edge T+CL.
  - RAM read is issued at T with 1-cycle latency; CL=3 adds one pipeline stage.
  - Read DQM is not modelled; the full word is driven.
  - Back-to-back READs every cycle are supported; each occupies its own pipeline slot.
- Data is captured at RAM read time: a WRITE to the same address one cycle after a READ does not alter the returned word.
- WRITE on an edge where DQ_OE=1: err[3] (bus conflict); the write still executes.
- PRECHARGE: A[10]=1 closes all banks, else bank BA. Precharging an IDLE bank is legal. Starts that bank's tRP counter.
- AUTO_REFRESH:
  - Any bank ACTIVE: err[4].
  - tRP not elapsed for any bank: err[2].
  - refresh_cnt increments and saturates at 16'hFFFF.
- Any valid command other than NOP while mode_valid=0, except LOAD_MODE and PRECHARGE: err[5] (init order).
- err bits are sticky until reset.
- Reset mid-read: pending read data is discarded and DQ_OE=0 on the next cycle.

Decomposition:
- Package sdram_pkg:
  - command encodings (CMD_*);
  - mode-register field positions;
  - error bit indices ERR_MODE, ERR_STATE, ERR_TIMING, ERR_BUS, ERR_REFRESH, ERR_INIT.
- Sub-module sdram_model_ram: ADDR_W x 16 single-port RAM, two byte write-enables, 1-cycle registered read.

Test Plan:
- Init sequence, then write/read:
  - Stimulus: PRECHARGE all, LOAD_MODE A=13'h0220 (CL2, BL1); ACTIVE BA=1 row=5, WRITE col=3 data 16'hA55A with DQM=00; READ col=3.
  - Required: DQ_OE high for exactly one cycle, sampled at edge T+2 with 16'hA55A; err=0.
- Byte masks:
  - Stimulus: write 16'h1234, then write 16'hFFFF with DQMH=1 DQML=0; read.
  - Required: 16'h12FF.
- CL3 and auto-precharge:
  - Stimulus: LOAD_MODE 13'h0230; READ with A[10]=1.
  - Required: data sampled at edge T+3; a following ACTIVE on that bank raises no err[1].
- Protocol errors:
  - READ to an IDLE bank -> err[1] set, no DQ_OE.
  - ACTIVE then READ one cycle later (T_RCD=2) -> err[2] set.
- Refresh:
  - Stimulus: 3 AUTO_REFRESH with all banks idle.
  - Required: refresh_cnt=3. AUTO_REFRESH with a bank open -> err[4] set.
- Reset during a pending CL3 read:
  - Required: no DQ_OE pulse; err=0 and refresh_cnt=0; previously written data is still readable after re-init.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDR SDRAM device model: command encodings,
// mode-register fields, bank states and error-flag bit positions.
package sdram_pkg;

  // Encoded as {nRAS, nCAS, nWE} while nCS=0 and CKE=1.
  typedef enum logic [2:0] {
    CMD_LOAD_MODE    = 3'b000,
    CMD_AUTO_REFRESH = 3'b001,
    CMD_PRECHARGE    = 3'b010,
    CMD_ACTIVE       = 3'b011,
    CMD_WRITE        = 3'b100,
    CMD_READ         = 3'b101,
    CMD_BURST_TERM   = 3'b110,
    CMD_NOP          = 3'b111
  } cmd_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  localparam int MODE_CL_LSB = 4;
  localparam int MODE_CL_MSB = 6;
  localparam int MODE_BL_LSB = 0;
  localparam int MODE_BL_MSB = 2;
  localparam int AP_BIT      = 10;

  localparam int ERR_MODE    = 0;
  localparam int ERR_STATE   = 1;
  localparam int ERR_TIMING  = 2;
  localparam int ERR_BUS     = 3;
  localparam int ERR_REFRESH = 4;
  localparam int ERR_INIT    = 5;

  localparam int N_BANKS = 4;
  localparam int TMR_W   = 4;

endpackage

// File: rtl/sdram_model_ram.sv
// Backing store for the SDRAM model: single-port, two byte write-enables,
// registered read (read-first on a simultaneous write).
module sdram_model_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata_q;

  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; contents deliberately survive a device reset.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i[0]) mem[addr_i][7:0]  <= wdata_i[7:0];
      if (we_i[1]) mem[addr_i][15:8] <= wdata_i[15:8];
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_chip_model.sv
// Device end of a 16-bit SDR SDRAM bus: decodes commands, tracks per-bank
// rows and timing, returns read data at CAS latency and flags violations.
module sdram_chip_model
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int COL_W  = 9,
  parameter int T_RCD  = 2,
  parameter int T_RP   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic        SDRAM_CKE,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] SDRAM_DQ_I,
  output logic [15:0] SDRAM_DQ_O,
  output logic        SDRAM_DQ_OE,
  output logic [5:0]  err,
  output logic [15:0] refresh_cnt
);

  bank_state_e      bank_q [N_BANKS];
  bank_state_e      bank_d [N_BANKS];
  logic [12:0]      row_q  [N_BANKS];
  logic [12:0]      row_d  [N_BANKS];
  logic [TMR_W-1:0] rcd_q  [N_BANKS];
  logic [TMR_W-1:0] rcd_d  [N_BANKS];
  logic [TMR_W-1:0] rp_q   [N_BANKS];
  logic [TMR_W-1:0] rp_d   [N_BANKS];

  logic        mode_valid_q, mode_valid_d;
  logic        cl3_q, cl3_d;
  logic [5:0]  err_q, err_d;
  logic [15:0] ref_q, ref_d;

  logic        rd_v1_q, rd_cl3_1_q, rd_v2_q, dq_oe_q;
  logic [15:0] rd_data2_q, dq_o_q;

  cmd_e              cmd;
  logic [2:0]        mode_cl, mode_bl;
  logic [ADDR_W-1:0] word_addr;
  logic              any_active, any_rp_busy;
  logic              ram_en, rd_fire, rd_cl3;
  logic [1:0]        ram_we;
  logic [15:0]       ram_rdata;

  assign cmd = (!SDRAM_nCS && SDRAM_CKE)
             ? cmd_e'({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE}) : CMD_NOP;
  assign mode_cl   = SDRAM_A[MODE_CL_MSB:MODE_CL_LSB];
  assign mode_bl   = SDRAM_A[MODE_BL_MSB:MODE_BL_LSB];
  assign word_addr = ADDR_W'({SDRAM_BA, row_q[SDRAM_BA], SDRAM_A[COL_W-1:0]});
  // Without a programmed mode the device falls back to CL=2.
  assign rd_cl3    = cl3_q && mode_valid_q;

  always_comb begin
    any_active  = 1'b0;
    any_rp_busy = 1'b0;
    for (int b = 0; b < N_BANKS; b++) begin
      any_active  = any_active  | (bank_q[b] == BANK_ACTIVE);
      any_rp_busy = any_rp_busy | (rp_q[b] != '0);
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    bank_d       = bank_q;
    row_d        = row_q;
    mode_valid_d = mode_valid_q;
    cl3_d        = cl3_q;
    err_d        = err_q;
    ref_d        = ref_q;
    ram_en       = 1'b0;
    ram_we       = 2'b00;
    rd_fire      = 1'b0;
    for (int b = 0; b < N_BANKS; b++) begin
      rcd_d[b] = (rcd_q[b] != '0) ? rcd_q[b] - TMR_W'(1) : '0;
      rp_d[b]  = (rp_q[b]  != '0) ? rp_q[b]  - TMR_W'(1) : '0;
    end

    if (cmd != CMD_NOP && cmd != CMD_LOAD_MODE && cmd != CMD_PRECHARGE && !mode_valid_q)
      err_d[ERR_INIT] = 1'b1;

    case (cmd)
      CMD_LOAD_MODE: begin
        mode_valid_d = 1'b1;
        if (any_active) err_d[ERR_STATE] = 1'b1;
        if ((mode_cl != 3'd2 && mode_cl != 3'd3) || mode_bl != 3'd0)
          err_d[ERR_MODE] = 1'b1;
        else
          cl3_d = (mode_cl == 3'd3);
      end
      CMD_ACTIVE: begin
        if (bank_q[SDRAM_BA] == BANK_ACTIVE) err_d[ERR_STATE]  = 1'b1;
        if (rp_q[SDRAM_BA] != '0)            err_d[ERR_TIMING] = 1'b1;
        bank_d[SDRAM_BA] = BANK_ACTIVE;
        row_d[SDRAM_BA]  = SDRAM_A;
        rcd_d[SDRAM_BA]  = TMR_W'(T_RCD - 1);
      end
      CMD_READ, CMD_WRITE: begin
        if (bank_q[SDRAM_BA] == BANK_IDLE) begin
          err_d[ERR_STATE] = 1'b1;
        end else begin
          if (rcd_q[SDRAM_BA] != '0) err_d[ERR_TIMING] = 1'b1;
          if (!mode_valid_q)         err_d[ERR_MODE]   = 1'b1;
          ram_en = 1'b1;
          if (cmd == CMD_WRITE) begin
            ram_we = {~SDRAM_DQMH, ~SDRAM_DQML};
            if (dq_oe_q) err_d[ERR_BUS] = 1'b1;
          end else begin
            rd_fire = 1'b1;
          end
          if (SDRAM_A[AP_BIT]) bank_d[SDRAM_BA] = BANK_IDLE;
        end
      end
      CMD_PRECHARGE: begin
        for (int b = 0; b < N_BANKS; b++) begin
          if (SDRAM_A[AP_BIT] || SDRAM_BA == 2'(b)) begin
            bank_d[b] = BANK_IDLE;
            rp_d[b]   = TMR_W'(T_RP - 1);
          end
        end
      end
      CMD_AUTO_REFRESH: begin
        if (any_active)  err_d[ERR_REFRESH] = 1'b1;
        if (any_rp_busy) err_d[ERR_TIMING]  = 1'b1;
        if (ref_q != 16'hFFFF) ref_d = ref_q + 16'd1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < N_BANKS; b++) begin
        bank_q[b] <= BANK_IDLE;
        row_q[b]  <= '0;
        rcd_q[b]  <= '0;
        rp_q[b]   <= '0;
      end
      mode_valid_q <= 1'b0;
      cl3_q        <= 1'b0;
      err_q        <= '0;
      ref_q        <= '0;
    end else begin
      bank_q       <= bank_d;
      row_q        <= row_d;
      rcd_q        <= rcd_d;
      rp_q         <= rp_d;
      mode_valid_q <= mode_valid_d;
      cl3_q        <= cl3_d;
      err_q        <= err_d;
      ref_q        <= ref_d;
    end
  end

  // RAM output is stage 1; CL=3 reads pass through one extra stage before
  // reaching the pin register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v1_q    <= 1'b0;
      rd_cl3_1_q <= 1'b0;
      rd_v2_q    <= 1'b0;
      rd_data2_q <= '0;
      dq_oe_q    <= 1'b0;
      dq_o_q     <= '0;
    end else begin
      rd_v1_q    <= rd_fire;
      rd_cl3_1_q <= rd_cl3;
      rd_v2_q    <= rd_v1_q && rd_cl3_1_q;
      rd_data2_q <= ram_rdata;
      if (rd_v2_q) begin
        dq_oe_q <= 1'b1;
        dq_o_q  <= rd_data2_q;
      end else if (rd_v1_q && !rd_cl3_1_q) begin
        dq_oe_q <= 1'b1;
        dq_o_q  <= ram_rdata;
      end else begin
        dq_oe_q <= 1'b0;
      end
    end
  end

  sdram_model_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (word_addr),
    .wdata_i (SDRAM_DQ_I),
    .rdata_o (ram_rdata)
  );

  assign SDRAM_DQ_O  = dq_o_q;
  assign SDRAM_DQ_OE = dq_oe_q;
  assign err         = err_q;
  assign refresh_cnt = ref_q;

endmodule
